// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   state_t        controller FSM state encoding
//   REG_W          architectural register index width
//   DRAIN_CYC_DEF  default halt drain length (EX, MEM, WB)
//   CNT_W_DEF      default stall counter width
package hazard_pkg;

    localparam int REG_W         = 3;
    localparam int DRAIN_CYC_DEF = 3;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [1:0] {
        RST_BUB = 2'd0,
        RUN     = 2'd1,
        HALT    = 2'd2
    } state_t;

endpackage

// File: rtl/raw_detect.sv
// raw_detect: combinational read-after-write comparator for one producing stage.
// Ports:
//   rs, rt          source registers of the instruction in ID
//   use_rs, use_rt  the matching source is actually read
//   rd              destination register of the producing stage
//   wr_en           producing stage writes rd
//   hit             a used source matches a written destination
module raw_detect
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [REG_W-1:0] rd,
    input  logic             wr_en,
    output logic             hit
);

    // r0 is an ordinary register here, so no zero-index exclusion.
    assign hit = wr_en & ((use_rs & (rs == rd)) | (use_rt & (rt == rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the five-stage core.
// Sole driver of the pipeline register enables, the IF/ID and ID/EX flushes
// and the PC write enable.
//
// Build option: HAZ_FWD_EN -- when defined, forwarding covers ALU results and
// only load-use stalls; when undefined, any producer match in ID/EX or EX/MEM
// stalls until it retires past EX/MEM.
//
// Ports:
//   clk, rst                     core clock, async active-low reset
//   if_id_rs/rt, if_id_use_rs/rt sources of the instruction in ID
//   if_id_halt                   instruction in ID is HALT
//   id_ex_rd/regwrite/memread    producer in ID/EX
//   ex_mem_rd/regwrite           producer in EX/MEM
//   br_taken_ex                  taken branch/jump resolved in EX
//   icache_busy, dcache_busy     cache miss in progress
//   pc_wrt, wrt_*                PC and pipeline register enables
//   flush_IF_ID, flush_ID_EX     synchronous clear to NOP
//   halted                       pipeline drained after HALT
//   stall_cycles                 saturating count of stalled RUN cycles
//
// state   | meaning
// --------+-----------------------------------------------------------
// RST_BUB | single cycle after reset: flush IF/ID and ID/EX, hold PC
// RUN     | normal issue, hazard priority rules applied
// HALT    | HALT accepted: fetch frozen, drain down-counter running
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_use_rs,
    input  logic             if_id_use_rt,
    input  logic             if_id_halt,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_regwrite,
    input  logic             id_ex_memread,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic             ex_mem_regwrite,
    input  logic             br_taken_ex,
    input  logic             icache_busy,
    input  logic             dcache_busy,
    output logic             pc_wrt,
    output logic             wrt_IF_ID,
    output logic             wrt_ID_EX,
    output logic             wrt_EX_MEM,
    output logic             wrt_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    state_t           state, state_nxt;
    logic             redir_pend, redir_pend_nxt;
    logic [1:0]       drain, drain_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             id_ex_hit, ex_mem_hit;
    logic             raw_stall;

    raw_detect u_raw_id_ex (
        .rs     (if_id_rs),
        .rt     (if_id_rt),
        .use_rs (if_id_use_rs),
        .use_rt (if_id_use_rt),
        .rd     (id_ex_rd),
        .wr_en  (id_ex_regwrite),
        .hit    (id_ex_hit)
    );

    raw_detect u_raw_ex_mem (
        .rs     (if_id_rs),
        .rt     (if_id_rt),
        .use_rs (if_id_use_rs),
        .use_rt (if_id_use_rt),
        .rd     (ex_mem_rd),
        .wr_en  (ex_mem_regwrite),
        .hit    (ex_mem_hit)
    );

`ifdef HAZ_FWD_EN
    logic unused_ex_mem_hit;
    assign unused_ex_mem_hit = ex_mem_hit;
    assign raw_stall = id_ex_memread & id_ex_hit;
`else
    // Load-use is a subset of the ID/EX match, so it needs no separate term.
    logic unused_memread;
    assign unused_memread = id_ex_memread;
    assign raw_stall = id_ex_hit | ex_mem_hit;
`endif

    // State register and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RST_BUB;
            redir_pend <= 1'b0;
            drain      <= 2'd0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            redir_pend <= redir_pend_nxt;
            drain      <= drain_nxt;
            if ((state == RUN) && !pc_wrt && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt      = state;
        redir_pend_nxt = redir_pend;
        drain_nxt      = drain;
        case (state)
            RST_BUB: state_nxt = RUN;
            RUN: begin
                // A dcache freeze holds everything, including a pending redirect.
                if (!dcache_busy) begin
                    if (br_taken_ex)
                        redir_pend_nxt = icache_busy;
                    else if (!icache_busy)
                        redir_pend_nxt = 1'b0;
                    if (!br_taken_ex && !raw_stall && !icache_busy && if_id_halt) begin
                        state_nxt = HALT;
                        drain_nxt = 2'(DRAIN_CYC);
                    end
                end
            end
            HALT: begin
                if (drain != 2'd0)
                    drain_nxt = drain - 2'd1;
            end
            default: state_nxt = RST_BUB;
        endcase
    end

    // Output logic.
    always_comb begin
        pc_wrt      = 1'b1;
        wrt_IF_ID   = 1'b1;
        wrt_ID_EX   = 1'b1;
        wrt_EX_MEM  = 1'b1;
        wrt_MEM_WB  = 1'b1;
        flush_IF_ID = 1'b0;
        flush_ID_EX = 1'b0;
        halted      = 1'b0;
        case (state)
            RST_BUB: begin
                pc_wrt      = 1'b0;
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
            end
            RUN: begin
                if (dcache_busy) begin
                    pc_wrt     = 1'b0;
                    wrt_IF_ID  = 1'b0;
                    wrt_ID_EX  = 1'b0;
                    wrt_EX_MEM = 1'b0;
                    wrt_MEM_WB = 1'b0;
                end else if (br_taken_ex) begin
                    flush_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                end else if (raw_stall) begin
                    pc_wrt      = 1'b0;
                    wrt_IF_ID   = 1'b0;
                    flush_ID_EX = 1'b1;
                end else if (icache_busy) begin
                    pc_wrt      = 1'b0;
                    flush_IF_ID = 1'b1;
                end else if (if_id_halt) begin
                    pc_wrt = 1'b0;
                end
                // The fetch completing after a redirect belongs to the old path.
                if (!dcache_busy && !br_taken_ex && redir_pend && !icache_busy)
                    flush_IF_ID = 1'b1;
            end
            HALT: begin
                pc_wrt      = 1'b0;
                wrt_IF_ID   = 1'b0;
                flush_ID_EX = 1'b1;
                halted      = (drain == 2'd0);
            end
            default: begin
                pc_wrt      = 1'b0;
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
            end
        endcase
    end

    assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// ctl packs {pc_wrt, wrt_IF_ID, wrt_ID_EX, wrt_EX_MEM, wrt_MEM_WB,
//            flush_IF_ID, flush_ID_EX, halted}.
module tb_hazard_ctrl;

    localparam logic [7:0] C_BUB    = 8'b0111_1110;
    localparam logic [7:0] C_RUN    = 8'b1111_1000;
    localparam logic [7:0] C_LU     = 8'b0011_1010;
    localparam logic [7:0] C_BR     = 8'b1111_1110;
    localparam logic [7:0] C_IBUSY  = 8'b0111_1100;
    localparam logic [7:0] C_REDIR  = 8'b1111_1100;
    localparam logic [7:0] C_FREEZE = 8'b0000_0000;
    localparam logic [7:0] C_HENTRY = 8'b0111_1000;
    localparam logic [7:0] C_DRAIN  = 8'b0011_1010;
    localparam logic [7:0] C_HALTED = 8'b0011_1011;

`ifdef HAZ_FWD_EN
    localparam logic [7:0] C_RAW    = C_RUN;
    localparam int         RAW_STL  = 0;
`else
    localparam logic [7:0] C_RAW    = C_LU;
    localparam int         RAW_STL  = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
    logic        if_id_use_rs, if_id_use_rt, if_id_halt;
    logic        id_ex_regwrite, id_ex_memread, ex_mem_regwrite;
    logic        br_taken_ex, icache_busy, dcache_busy;
    logic        pc_wrt, wrt_IF_ID, wrt_ID_EX, wrt_EX_MEM, wrt_MEM_WB;
    logic        flush_IF_ID, flush_ID_EX, halted;
    logic [15:0] stall_cycles;
    logic [7:0]  ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {pc_wrt, wrt_IF_ID, wrt_ID_EX, wrt_EX_MEM, wrt_MEM_WB,
                  flush_IF_ID, flush_ID_EX, halted};

    always #5 clk = ~clk;

    hazard_ctrl #(.DRAIN_CYC(3), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .if_id_use_rs    (if_id_use_rs),
        .if_id_use_rt    (if_id_use_rt),
        .if_id_halt      (if_id_halt),
        .id_ex_rd        (id_ex_rd),
        .id_ex_regwrite  (id_ex_regwrite),
        .id_ex_memread   (id_ex_memread),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .br_taken_ex     (br_taken_ex),
        .icache_busy     (icache_busy),
        .dcache_busy     (dcache_busy),
        .pc_wrt          (pc_wrt),
        .wrt_IF_ID       (wrt_IF_ID),
        .wrt_ID_EX       (wrt_ID_EX),
        .wrt_EX_MEM      (wrt_EX_MEM),
        .wrt_MEM_WB      (wrt_MEM_WB),
        .flush_IF_ID     (flush_IF_ID),
        .flush_ID_EX     (flush_ID_EX),
        .halted          (halted),
        .stall_cycles    (stall_cycles)
    );

    task automatic idle();
        if_id_rs = 3'd0; if_id_rt = 3'd0; if_id_use_rs = 1'b0; if_id_use_rt = 1'b0;
        if_id_halt = 1'b0; id_ex_rd = 3'd0; id_ex_regwrite = 1'b0; id_ex_memread = 1'b0;
        ex_mem_rd = 3'd0; ex_mem_regwrite = 1'b0; br_taken_ex = 1'b0;
        icache_busy = 1'b0; dcache_busy = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first RUN cycle.
    task automatic do_reset();
        idle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL rst_hold_ctl got %b want %b", ctl, C_BUB); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_hold_cnt got %0d want 0", stall_cycles); end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL rst_bub_c0 got %b want %b", ctl, C_BUB); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL rst_run_c1 got %b want %b", ctl, C_RUN); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_c1_cnt got %0d want 0", stall_cycles); end
    endtask

    task automatic test_load_use();
        do_reset();
        // Unused source never matches.
        id_ex_rd = 3'd3; id_ex_regwrite = 1'b1; id_ex_memread = 1'b1;
        if_id_rs = 3'd3; if_id_use_rs = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_unused got %b want %b", ctl, C_RUN); end
        next_cycle();
        if_id_use_rs = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs got %b want %b", ctl, C_LU); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_release got %b want %b", ctl, C_RUN); end
        checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", stall_cycles); end
        next_cycle();
        // rt path, and r0 is an ordinary register.
        id_ex_rd = 3'd0; id_ex_regwrite = 1'b1; id_ex_memread = 1'b1;
        if_id_rt = 3'd0; if_id_use_rt = 1'b1; if_id_rs = 3'd5;
        @(negedge clk);
        checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rt_r0 got %b want %b", ctl, C_LU); end
        next_cycle();
        // A load that does not write a register is no hazard.
        id_ex_rd = 3'd5; id_ex_regwrite = 1'b0; id_ex_memread = 1'b1;
        if_id_rs = 3'd5; if_id_use_rs = 1'b1; if_id_use_rt = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_nowrite got %b want %b", ctl, C_RUN); end
        checks++; if (stall_cycles !== 16'd2) begin errors++; $display("FAIL lu_cnt2 got %0d want 2", stall_cycles); end
    endtask

    task automatic test_branch_icache();
        do_reset();
        br_taken_ex = 1'b1; icache_busy = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_cycle got %b want %b", ctl, C_BR); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            br_taken_ex = 1'b0;
            @(negedge clk);
            checks++; if (ctl !== C_IBUSY) begin errors++; $display("FAIL br_ibusy%0d got %b want %b", i, ctl, C_IBUSY); end
        end
        next_cycle();
        icache_busy = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL br_redir got %b want %b", ctl, C_REDIR); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL br_pend_clr got %b want %b", ctl, C_RUN); end
        checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL br_cnt got %0d want 3", stall_cycles); end
        next_cycle();
        // Branch with icache idle: no redirect flush afterwards.
        br_taken_ex = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_fast got %b want %b", ctl, C_BR); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL br_fast_after got %b want %b", ctl, C_RUN); end
    endtask

    task automatic test_dcache_freeze();
        do_reset();
        dcache_busy = 1'b1; br_taken_ex = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL dc_freeze%0d got %b want %b", i, ctl, C_FREEZE); end
            checks++; if (stall_cycles !== 16'(i)) begin errors++; $display("FAIL dc_cnt%0d got %0d want %0d", i, stall_cycles, i); end
            next_cycle();
        end
        dcache_busy = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== C_BR) begin errors++; $display("FAIL dc_flush got %b want %b", ctl, C_BR); end
        checks++; if (stall_cycles !== 16'd5) begin errors++; $display("FAIL dc_cnt got %0d want 5", stall_cycles); end
    endtask

    task automatic test_halt();
        do_reset();
        // icache miss outranks HALT: stays in RUN.
        if_id_halt = 1'b1; icache_busy = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== C_IBUSY) begin errors++; $display("FAIL halt_ibusy got %b want %b", ctl, C_IBUSY); end
        next_cycle();
        icache_busy = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== C_HENTRY) begin errors++; $display("FAIL halt_entry got %b want %b", ctl, C_HENTRY); end
        next_cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ctl !== C_DRAIN) begin errors++; $display("FAIL halt_drain%0d got %b want %b", i, ctl, C_DRAIN); end
            next_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (ctl !== C_HALTED) begin errors++; $display("FAIL halt_done%0d got %b want %b", i, ctl, C_HALTED); end
            next_cycle();
        end
        checks++; if (stall_cycles !== 16'd2) begin errors++; $display("FAIL halt_cnt got %0d want 2", stall_cycles); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        if_id_halt = 1'b1;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== C_DRAIN) begin errors++; $display("FAIL mid_pre got %b want %b", ctl, C_DRAIN); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL mid_async got %b want %b", ctl, C_BUB); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", stall_cycles); end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL mid_bub got %b want %b", ctl, C_BUB); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL mid_run got %b want %b", ctl, C_RUN); end
    endtask

    task automatic test_raw();
        do_reset();
        // ADD r2 in ID/EX, SUB reads r2.
        id_ex_rd = 3'd2; id_ex_regwrite = 1'b1;
        if_id_rs = 3'd2; if_id_use_rs = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== C_RAW) begin errors++; $display("FAIL raw_idex got %b want %b", ctl, C_RAW); end
        next_cycle();
        // ADD moved on to EX/MEM, bubble in ID/EX.
        id_ex_rd = 3'd0; id_ex_regwrite = 1'b0;
        ex_mem_rd = 3'd2; ex_mem_regwrite = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== C_RAW) begin errors++; $display("FAIL raw_exmem got %b want %b", ctl, C_RAW); end
        next_cycle();
        ex_mem_regwrite = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL raw_clear got %b want %b", ctl, C_RUN); end
        checks++; if (stall_cycles !== 16'(RAW_STL)) begin errors++; $display("FAIL raw_cnt got %0d want %0d", stall_cycles, RAW_STL); end
    endtask

    initial begin
        idle();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_branch_icache();
        test_dcache_freeze();
        test_halt();
        test_reset_mid_drain();
        test_raw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
